fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Memory-side consumer of the program counter value.
- Reads the instruction at PC and computes the effective address (EA) for memory-reference instructions: page-zero or current-page, direct or indirect, with auto-index write-back for 0o010–0o017.
- Signals the program counter to advance.
- Sits between the program counter and the 4K×12 core memory port.

Parameters:
- AW, 12, memory address width (PDP-8 field size).
- DW, 12, data word width.

Ports:
- CLK input 1 system clock, rising edge.
- CLR input 1 reset, asynchronous, active-high.
- PC input 12 current program counter value, sampled on accepted START.
- START input 1 begin instruction fetch; ignored unless IDLE.
- MEM_ADDR output 12 memory address.
- MEM_RD output 1 read request, held until ACK.
- MEM_WR output 1 write request, held until ACK.
- MEM_WDATA output 12 write data (auto-index result).
- MEM_RDATA input 12 read data, valid when MEM_ACK=1.
- MEM_ACK input 1 access complete, sampled at CLK rise.
- IR output 12 fetched instruction.
- EA output 12 effective address (0 for IOT/OPR).
- PC_ADV output 1 one-cycle pulse: program counter increments.
- BUSY output 1 high in every state except IDLE.
- DONE output 1 one-cycle pulse: IR/EA valid.

Behaviour:
- Reset: CLR async forces state IDLE.
  - IR, EA, MEM_ADDR, MEM_WDATA = 0.
  - MEM_RD, MEM_WR, PC_ADV, DONE = 0.
  - Applies mid-access: requests drop immediately; a pending ACK is ignored.
- States: IDLE, FETCH, DECODE, DEFER, AUTOINC, FIN.
- IDLE, START=1 → FETCH:
  - Latch PC into internal IPC.
  - MEM_ADDR=PC, MEM_RD=1.
- FETCH:
  - MEM_RD, MEM_ADDR held stable until MEM_ACK=1.
  - On ACK edge: IR←MEM_RDATA, MEM_RD←0, PC_ADV=1 for the next cycle, → DECODE.
- DECODE (one cycle):
  - MRI = IR[11:9] ≤ 5.
  - Direct address DA:
    - {5'b0, IR[6:0]} if IR[7]=0.
    - {IPC[11:7], IR[6:0]} if IR[7]=1.
  - Non-MRI: EA←0, → FIN.
  - MRI with IR[8]=0: EA←DA, → FIN.
  - MRI with IR[8]=1: MEM_ADDR←DA, MEM_RD←1, → DEFER.
- DEFER:
  - On ACK: MEM_RD←0.
  - If DA in 0o0010..0o0017 (auto-index):
    - MEM_WDATA←RDATA+1, mod 2^12; 0o7777 wraps to 0o0000.
    - MEM_WR←1, EA←RDATA+1, → AUTOINC.
  - Else: EA←RDATA, → FIN.
- AUTOINC:
  - MEM_ADDR=DA, MEM_WR held until ACK.
  - On ACK: MEM_WR←0, → FIN.
- FIN: DONE=1 for one cycle, → IDLE. IR and EA hold until the next accepted START.
- Latency, ACK asserted in the first request cycle:
  - Direct/non-MRI: DONE 3 cycles after START edge.
  - Indirect: 4 cycles.
  - Auto-index: 5 cycles.
  - Each wait cycle adds 1.
- START while BUSY: ignored. START in the FIN cycle: ignored.
- MEM_RD and MEM_WR are never both high.
- MEM_ACK outside FETCH/DEFER/AUTOINC: ignored.
- PC_ADV fires exactly once per fetch, never during DEFER/AUTOINC.

Optional Feature:
- Macro: PDP8_AUTOINDEX_EN.
- Defined: auto-index as above.
- Undefined: 0o0010..0o0017 treated as ordinary indirect; AUTOINC state and MEM_WR logic absent; MEM_WR tied 0, MEM_WDATA tied 0.

Decomposition:
- Shared package pdp8_pkg:
  - State enum for the fetch FSM.
  - Opcode constants OP_AND..OP_OPR (0–7).
  - Constants AUTOIDX_LO=12'o0010, AUTOIDX_HI=12'o0017.
  - IR field positions: I bit 8, page bit 7, offset 6:0.
- One natural sub-module: ea_calc. Combinational DA generation from IR/IPC, plus the auto-index range check and increment.

Test Plan:
- PC=0o0200, mem[0200]=0o1234, zero-wait ACK → IR=0o1234, EA=0o0234, PC_ADV 1 pulse, DONE 3 cycles after START, no MEM_WR.
- PC=0o0300, mem[0300]=0o1410, mem[0010]=0o0777 → write mem[0010]=0o1000, EA=0o1000, DONE at cycle 5; without PDP8_AUTOINDEX_EN: EA=0o0777, no write, DONE at cycle 4.
- mem[PC]=0o5420 (JMP I 20), mem[0020]=0o3000 → EA=0o3000, one deferral read at 0o0020, no write.
- mem[PC]=0o7200 (OPR) → EA=0, only one memory read, DONE at cycle 3; IOT 0o6031 → same.
- mem[PC]=0o1417, mem[0017]=0o7777 → written 0o0000, EA=0o0000 (wrap).
- ACK delayed 3 cycles in FETCH → MEM_ADDR/MEM_RD stable throughout, DONE at cycle 6.
- CLR asserted mid-DEFER → all outputs 0 immediately, IDLE; the next START completes normally.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions for the instruction fetch path: FSM state
// encoding, opcode values, auto-index range and instruction field positions.
package pdp8_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_DEFER   = 3'd3,
    ST_AUTOINC = 3'd4,
    ST_FIN     = 3'd5
  } fetch_state_e;

  // Major opcodes, IR[11:9]. Values up to OP_JMP are memory-reference.
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  // Page-zero locations that increment when used as indirect pointers.
  localparam word_t AUTOIDX_LO = 12'o0010;
  localparam word_t AUTOIDX_HI = 12'o0017;

  // Instruction field positions.
  localparam int IR_OP_LO    = 9;
  localparam int IR_I_BIT    = 8;
  localparam int IR_PAGE_BIT = 7;
  localparam int IR_OFF_HI   = 6;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory port between the fetch unit (master) and the 4Kx12 core (slave).
// Requests are held until the slave answers with MEM_ACK.
interface fetch_unit_if #(
  parameter int AW = 12,
  parameter int DW = 12
);
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic          MEM_WR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_ACK;

  modport master (
    output MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/fetch_unit_ea_calc.sv
// Combinational effective-address helper: forms the direct address from the
// instruction and the page of the fetch PC, classifies the instruction, and
// (with PDP8_AUTOINDEX_EN) checks the auto-index range and increments the
// pointer word read during deferral.
module ea_calc
  import pdp8_pkg::*;
(
  input  word_t      ir_i,
  input  logic [4:0] page_i,
  output word_t      da_o,
  output logic       is_mri_o,
  output logic       is_ind_o
`ifdef PDP8_AUTOINDEX_EN
  ,
  input  word_t      rdata_i,
  output logic       autoidx_o,
  output word_t      rdata_inc_o
`endif
);

  // Page bit selects current page (fetch PC high bits) or page zero.
  always_comb begin
    is_mri_o = (ir_i[11:IR_OP_LO] <= OP_JMP);
    is_ind_o = ir_i[IR_I_BIT];
    if (ir_i[IR_PAGE_BIT]) da_o = {page_i, ir_i[IR_OFF_HI:0]};
    else                   da_o = {5'b0, ir_i[IR_OFF_HI:0]};
  end

`ifdef PDP8_AUTOINDEX_EN
  // Pointer increment wraps 7777 to 0000 naturally in 12 bits.
  always_comb begin
    autoidx_o   = (da_o >= AUTOIDX_LO) && (da_o <= AUTOIDX_HI);
    rdata_inc_o = rdata_i + 12'd1;
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// PDP-8 instruction fetch unit: reads the instruction at PC, resolves the
// effective address (direct, indirect, auto-index) and pulses PC_ADV once
// per fetch. Optional macro PDP8_AUTOINDEX_EN enables auto-index write-back
// for pointers at 0010..0017; without it those are plain indirect pointers.
module fetch_unit
  import pdp8_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 12
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic [AW-1:0] PC,
  input  logic          START,
  fetch_unit_if.master  mem,
  output logic [DW-1:0] IR,
  output logic [AW-1:0] EA,
  output logic          PC_ADV,
  output logic          BUSY,
  output logic          DONE
);

  fetch_state_e  state_q, state_d;
  logic [4:0]    ipc_page_q, ipc_page_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ea_q, ea_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;

  word_t da;
  logic  is_mri;
  logic  is_ind;

`ifdef PDP8_AUTOINDEX_EN
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          autoidx;
  word_t         rdata_inc;
`endif

  ea_calc u_ea_calc (
    .ir_i        (ir_q),
    .page_i      (ipc_page_q),
    .da_o        (da),
    .is_mri_o    (is_mri),
    .is_ind_o    (is_ind)
`ifdef PDP8_AUTOINDEX_EN
    ,
    .rdata_i     (mem.MEM_RDATA),
    .autoidx_o   (autoidx),
    .rdata_inc_o (rdata_inc)
`endif
  );

  // Next-state and datapath update for the fetch / decode / defer sequence.
  always_comb begin
    // NOTE: every target gets a default (hold) first so no path can infer a latch.
    state_d    = state_q;
    ipc_page_d = ipc_page_q;
    ir_d       = ir_q;
    ea_d       = ea_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
`ifdef PDP8_AUTOINDEX_EN
    wr_d       = wr_q;
    wdata_d    = wdata_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          ipc_page_d = PC[AW-1:AW-5];
          addr_d     = PC;
          rd_d       = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem.MEM_ACK) begin
          ir_d    = mem.MEM_RDATA;
          rd_d    = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!is_mri) begin
          ea_d    = '0;
          state_d = ST_FIN;
        end else if (!is_ind) begin
          ea_d    = da;
          state_d = ST_FIN;
        end else begin
          addr_d  = da;
          rd_d    = 1'b1;
          state_d = ST_DEFER;
        end
      end
      ST_DEFER: begin
        if (mem.MEM_ACK) begin
          rd_d    = 1'b0;
          ea_d    = mem.MEM_RDATA;
          state_d = ST_FIN;
`ifdef PDP8_AUTOINDEX_EN
          // Auto-index pointer: use and write back the incremented value;
          // MEM_ADDR already holds the pointer address for the write.
          if (autoidx) begin
            ea_d    = rdata_inc;
            wdata_d = rdata_inc;
            wr_d    = 1'b1;
            state_d = ST_AUTOINC;
          end
`endif
        end
      end
`ifdef PDP8_AUTOINDEX_EN
      ST_AUTOINC: begin
        if (mem.MEM_ACK) begin
          wr_d    = 1'b0;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; CLR drops any in-flight request at once.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      ipc_page_q <= '0;
      ir_q       <= '0;
      ea_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
`ifdef PDP8_AUTOINDEX_EN
      wr_q       <= 1'b0;
      wdata_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q    <= state_d;
      ipc_page_q <= ipc_page_d;
      ir_q       <= ir_d;
      ea_q       <= ea_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
`ifdef PDP8_AUTOINDEX_EN
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
`endif
    end
  end

  assign mem.MEM_ADDR = addr_q;
  assign mem.MEM_RD   = rd_q;
`ifdef PDP8_AUTOINDEX_EN
  assign mem.MEM_WR    = wr_q;
  assign mem.MEM_WDATA = wdata_q;
`else
  assign mem.MEM_WR    = 1'b0;
  assign mem.MEM_WDATA = '0;
`endif

  assign IR     = ir_q;
  assign EA     = ea_q;
  // DECODE is entered only from a completed fetch, so this is one pulse per fetch.
  assign PC_ADV = (state_q == ST_DECODE);
  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = (state_q == ST_FIN);

endmodule
